// File: rtl/qam16_tx_pkg.sv
// Shared definitions for the 16QAM transmit rail: symbol levels, the
// 129-tap SRRC prototype (1s17) and a bounded coefficient lookup.
package qam16_tx_pkg;

    localparam int OSR            = 4;
    localparam int NUM_TAPS       = 129;
    localparam int TAPS_PER_PHASE = 33;
    localparam int WIDTH          = 18;

    localparam logic signed [WIDTH-1:0] LEVEL_3 = 18'sd98304;
    localparam logic signed [WIDTH-1:0] LEVEL_1 = 18'sd32768;

    typedef logic [1:0] gray_sym_t;

    // First half of the symmetric prototype, H[0..64]; H[n] = H[128-n].
    localparam logic signed [WIDTH-1:0] H_HALF [0:64] = '{
        -18'sd4,     18'sd1,     18'sd6,     18'sd10,    18'sd10,
         18'sd2,    -18'sd10,   -18'sd20,   -18'sd20,   -18'sd5,
         18'sd20,    18'sd30,    18'sd30,    18'sd10,   -18'sd30,
        -18'sd50,   -18'sd50,   -18'sd20,    18'sd40,    18'sd80,
         18'sd80,    18'sd30,   -18'sd50,   -18'sd120,  -18'sd130,
        -18'sd50,    18'sd100,   18'sd200,   18'sd200,   18'sd100,
        -18'sd100,  -18'sd300,  -18'sd300,  -18'sd200,   18'sd100,
         18'sd400,   18'sd500,   18'sd300,  -18'sd100,  -18'sd500,
        -18'sd800,  -18'sd700,  -18'sd200,   18'sd500,   18'sd1100,
         18'sd1200,  18'sd500,  -18'sd600,  -18'sd1600, -18'sd2000,
        -18'sd1300,  18'sd400,   18'sd2200,  18'sd3200,  18'sd2600,
         18'sd200,  -18'sd3100, -18'sd5900, -18'sd6400, -18'sd3200,
         18'sd4300,  18'sd15200, 18'sd27300, 18'sd36500, 18'sd40000
    };

    // H[idx] with zero outside 0..128 so polyphase indices past the end vanish.
    function automatic logic signed [WIDTH-1:0] h_coef(input int idx);
        if (idx < 0 || idx >= NUM_TAPS)
            return '0;
        else if (idx <= 64)
            return H_HALF[idx];
        else
            return H_HALF[128 - idx];
    endfunction

endpackage

// File: rtl/qam16_symbol_mapper.sv
// Gray-coded 2-bit 4-ASK symbol to signed 1s17 level.
module qam16_symbol_mapper
    import qam16_tx_pkg::*;
(
    input  logic [1:0]             sym,
    output logic signed [WIDTH-1:0] level
);

    // Gray mapping: 00 -0.75, 01 -0.25, 11 +0.25, 10 +0.75
    always_comb begin
        level = LEVEL_3;
        case (sym)
            2'b00:   level = -LEVEL_3;
            2'b01:   level = -LEVEL_1;
            2'b11:   level = LEVEL_1;
            default: level = LEVEL_3;
        endcase
    end

endmodule

// File: rtl/srrc_tx_interpolator.sv
// SRRC transmit pulse shaper, interpolate-by-4 polyphase, one rail.
// Pipeline: product regs -> 5 partial sums -> saturated output (3 enables).
// Build option SRRC_TX_IMPULSE_TEST_EN: replaces sym_in with a +0.75
// impulse every 64 symbols (zero level otherwise) for response checks.
module srrc_tx_interpolator
    import qam16_tx_pkg::*;
(
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             sam_clk_ena,
    input  logic             sym_clk_ena,
    input  logic [1:0]       sym_in,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    logic                         sym_load;
    logic [1:0]                   map_sym;
    logic signed [WIDTH-1:0]      map_level;
    logic signed [WIDTH-1:0]      new_level;
    logic signed [WIDTH-1:0]      s     [0:TAPS_PER_PHASE-1];
    logic signed [WIDTH-1:0]      coef  [0:TAPS_PER_PHASE-1];
    logic signed [2*WIDTH-1:0]    prod  [0:TAPS_PER_PHASE-1];
    logic signed [39:0]           psum_nxt [0:4];
    logic signed [39:0]           psum     [0:4];
    logic signed [39:0]           total;
    logic signed [39:0]           total_shr;
    logic signed [WIDTH-1:0]      y_nxt;
    logic [1:0]                   ph;

    // A symbol edge only counts when it lines up with a sample edge.
    assign sym_load = sam_clk_ena & sym_clk_ena;

    qam16_symbol_mapper u_mapper (
        .sym   (map_sym),
        .level (map_level)
    );

`ifdef SRRC_TX_IMPULSE_TEST_EN
    logic [5:0] imp_cnt;
    logic       unused_sym_in;

    assign unused_sym_in = ^sym_in;

    // Symbol counter: impulse on count 0, silence for the other 63 symbols.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n)
            imp_cnt <= '0;
        else if (sym_load)
            imp_cnt <= imp_cnt + 6'd1;
    end

    assign map_sym   = 2'b10;
    assign new_level = (imp_cnt == 6'd0) ? map_level : '0;
`else
    assign map_sym   = sym_in;
    assign new_level = map_level;
`endif

    // Symbol delay line shifts on each accepted symbol, otherwise holds.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < TAPS_PER_PHASE; k++) s[k] <= '0;
        end else if (sym_load) begin
            s[0] <= new_level;
            for (int k = 1; k < TAPS_PER_PHASE; k++) s[k] <= s[k-1];
        end
    end

    // Interpolation phase: cleared by a symbol, free-runs mod 4 otherwise.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n)
            ph <= '0;
        else if (sym_load)
            ph <= '0;
        else if (sam_clk_ena)
            ph <= ph + 2'd1;
    end

    // Coefficient for tap k of the current phase; indices past 128 read 0.
    always_comb begin
        for (int k = 0; k < TAPS_PER_PHASE; k++)
            coef[k] = h_coef(4 * k + int'(ph));
    end

    // Full-precision products of the pre-edge delay line and phase.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < TAPS_PER_PHASE; k++) prod[k] <= '0;
        end else if (sam_clk_ena) begin
            for (int k = 0; k < TAPS_PER_PHASE; k++)
                prod[k] <= 36'(s[k]) * 36'(coef[k]);
        end
    end

    // Groups of eight products; the last group holds only tap 32.
    always_comb begin
        for (int g = 0; g < 5; g++) psum_nxt[g] = '0;
        for (int g = 0; g < 4; g++)
            for (int j = 0; j < 8; j++)
                psum_nxt[g] = psum_nxt[g] + 40'(prod[8*g + j]);
        psum_nxt[4] = 40'(prod[32]);
    end

    // Partial-sum stage.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int g = 0; g < 5; g++) psum[g] <= '0;
        end else if (sam_clk_ena) begin
            for (int g = 0; g < 5; g++) psum[g] <= psum_nxt[g];
        end
    end

    // Final sum, rescale to 1s17 and clamp.
    always_comb begin
        total     = psum[0] + psum[1] + psum[2] + psum[3] + psum[4];
        total_shr = total >>> 17;
        if (total_shr > 40'sd131071)
            y_nxt = 18'sd131071;
        else if (total_shr < -40'sd131072)
            y_nxt = -18'sd131072;
        else
            y_nxt = total_shr[WIDTH-1:0];
    end

    // Output register and its one-cycle valid strobe.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= sam_clk_ena;
            if (sam_clk_ena)
                y <= y_nxt;
        end
    end

endmodule
